hazard_stall_unit: RTL and testbench

- Companion to the pipeline forwarding logic: it handles every hazard that forwarding cannot resolve.
- Hazards covered: load-use, load/ALU-to-branch in ID, and data-memory wait, plus IF/ID flush on a taken branch.
- Drives the write enables and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Keeps a saturating stall counter and a sticky memory-timeout flag.

---
 rtl/hazard_stall_unit_pkg.sv | 32 +++
 rtl/hazard_stall_unit_sat_counter.sv | 24 ++
 rtl/hazard_stall_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall unit.
// Holds the default register-address width, the FSM state encoding, the NOP
// instruction word loaded on flush/bubble, and the control-bundle constants
// the top module drives onto the pipeline register enables.
package hazard_stall_unit_pkg;

  localparam int PIPE_REG_W = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_STALL2 = 2'd1,
    MEM_WAIT  = 2'd2
  } hsu_state_e;

  // Instruction word the IF/ID and ID/EX registers load on flush or bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Pipeline-register control bundle.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } hsu_ctrl_t;

  localparam hsu_ctrl_t CTRL_RUN    = 5'b11000; // everything advances
  localparam hsu_ctrl_t CTRL_STALL  = 5'b00010; // hold PC/IF-ID, bubble into ID/EX
  localparam hsu_ctrl_t CTRL_FREEZE = 5'b00001; // whole pipe frozen, no bubble
  localparam hsu_ctrl_t CTRL_RESET  = 5'b00010; // state presented while rst_n=0

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en),
//        en (count enable), count (W-bit value, sticks at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit: resolves the hazards forwarding cannot (load-use,
// load/ALU result needed by a branch in ID, data-memory wait) and flushes
// IF/ID on a taken branch.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ID_rs, ID_rt, ID_uses_rt,       source operands of the ID instruction
//   ID_branch                       ID instruction compares rs/rt
//   IE_memread, IE_writeback,       ID/EX instruction: load / writes reg /
//   IE_registertowrite              destination register
//   mem_req, mem_ready              data-memory handshake in EX/MEM
//   branch_taken                    branch resolved taken in ID
//   pc_write, IFID_write,           load enables
//   IFID_flush, IDEX_bubble,        NOP insertion controls
//   pipe_hold                       freeze ID/EX, EX/MEM, MEM/WB
//   stall_count                     saturating count of pc_write=0 cycles
//   mem_timeout                     sticky: memory wait exceeded MAX_WAIT
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_W    = PIPE_REG_W,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_branch,
  input  logic             IE_memread,
  input  logic             IE_writeback,
  input  logic [REG_W-1:0] IE_registertowrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT - 1);

  hsu_state_e state, state_nx;
  hsu_state_e ret_state, ret_nx;  // where MEM_WAIT resumes (keeps an owed bubble)
  hsu_ctrl_t  ctrl;

  logic             hit_rs, hit_rt, lu, br, mem_stall;
  logic             wait_en, wait_clr;
  logic [CNT_W-1:0] wait_cnt;

  assign hit_rs    = (IE_registertowrite != '0) && (IE_registertowrite == ID_rs);
  assign hit_rt    = (ID_uses_rt || ID_branch) && (IE_registertowrite != '0) &&
                     (IE_registertowrite == ID_rt);
  assign lu        = IE_memread && (hit_rs || hit_rt);
  assign br        = ID_branch && IE_writeback && (hit_rs || hit_rt);
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    ctrl     = CTRL_RUN;
    state_nx = state;
    ret_nx   = ret_state;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          ctrl     = CTRL_FREEZE;
          state_nx = MEM_WAIT;
          ret_nx   = RUN;
        end else if (lu || br) begin
          ctrl = CTRL_STALL;
          // load feeding a branch compare needs a second bubble
          if (ID_branch && IE_memread) state_nx = BR_STALL2;
        end else begin
          ctrl            = CTRL_RUN;
          ctrl.ifid_flush = branch_taken;
        end
      end
      BR_STALL2: begin
        if (mem_stall) begin
          ctrl     = CTRL_FREEZE;
          state_nx = MEM_WAIT;
          ret_nx   = BR_STALL2;
        end else begin
          ctrl     = CTRL_STALL;
          state_nx = RUN;
        end
      end
      MEM_WAIT: begin
        ctrl = CTRL_FREEZE;
        if (mem_ready) state_nx = ret_state;
      end
      default: begin
        ctrl     = CTRL_STALL;
        state_nx = RUN;
        ret_nx   = RUN;
      end
    endcase
    // outputs are combinational from state, so reset must override them directly
    if (!rst_n) ctrl = CTRL_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign IFID_write  = ctrl.ifid_write;
  assign IFID_flush  = ctrl.ifid_flush;
  assign IDEX_bubble = ctrl.idex_bubble;
  assign pipe_hold   = ctrl.pipe_hold;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (!ctrl.pc_write),
    .count (stall_count)
  );

  assign wait_en  = (state == MEM_WAIT) && !mem_ready;
  assign wait_clr = (state == MEM_WAIT) && mem_ready;

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .count (wait_cnt)
  );

  // Set on the same edge at which wait_cnt reaches MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_timeout <= 1'b0;
    end else if (wait_en && (wait_cnt >= WAIT_LIM)) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (default parameters, and a small
// one with CNT_W=4, MAX_WAIT=4) share one stimulus stream; a behavioural
// model tracks "waiting for memory" and "bubbles still owed" and is compared
// with both instances every cycle, with hand-computed literal checks on top.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_rs, ID_rt, IE_registertowrite;
  logic       ID_uses_rt, ID_branch, IE_memread, IE_writeback;
  logic       mem_req, mem_ready, branch_taken;

  logic        pc_b, ifid_b, flush_b, bub_b, hold_b, to_b;
  logic [15:0] sc_b;
  logic        pc_s, ifid_s, flush_s, bub_s, hold_s, to_s;
  logic [3:0]  sc_s;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut_b (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .ID_branch(ID_branch), .IE_memread(IE_memread), .IE_writeback(IE_writeback),
    .IE_registertowrite(IE_registertowrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_b), .IFID_write(ifid_b),
    .IFID_flush(flush_b), .IDEX_bubble(bub_b), .pipe_hold(hold_b),
    .stall_count(sc_b), .mem_timeout(to_b)
  );

  hazard_stall_unit #(.CNT_W(4), .MAX_WAIT(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .ID_branch(ID_branch), .IE_memread(IE_memread), .IE_writeback(IE_writeback),
    .IE_registertowrite(IE_registertowrite), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_s), .IFID_write(ifid_s),
    .IFID_flush(flush_s), .IDEX_bubble(bub_s), .pipe_hold(hold_s),
    .stall_count(sc_s), .mem_timeout(to_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_waiting;        // memory freeze in progress (after its first cycle)
  int m_owed;           // extra bubbles still owed to a load-to-branch
  int m_wait_cycles;    // cycles spent waiting after the first freeze cycle
  int m_sc_b, m_sc_s;
  bit m_to_b, m_to_s;

  always @(negedge clk) begin
    bit e_pc, e_ifid, e_flush, e_bub, e_hold, src_match, hazard;
    if (!rst_n) begin
      m_waiting = 0; m_owed = 0; m_wait_cycles = 0;
      m_sc_b = 0; m_sc_s = 0; m_to_b = 0; m_to_s = 0;
      chk("rst_pc_write", {31'd0, pc_b}, 0);
      chk("rst_ifid_write", {31'd0, ifid_b}, 0);
      chk("rst_flush", {31'd0, flush_b}, 0);
      chk("rst_bubble", {31'd0, bub_b}, 1);
      chk("rst_hold", {31'd0, hold_b}, 0);
      chk("rst_stall_count", {16'd0, sc_b}, 0);
      chk("rst_timeout_s", {31'd0, to_s}, 0);
    end else begin
      src_match = (IE_registertowrite != 0) &&
                  (IE_registertowrite == ID_rs ||
                   ((ID_uses_rt || ID_branch) && IE_registertowrite == ID_rt));
      hazard = (IE_memread && src_match) || (ID_branch && IE_writeback && src_match);
      e_flush = 0;
      if (m_waiting || (mem_req && !mem_ready)) begin
        {e_pc, e_ifid, e_bub, e_hold} = 4'b0001;
      end else if (m_owed > 0) begin
        {e_pc, e_ifid, e_bub, e_hold} = 4'b0010;
        m_owed--;
      end else if (hazard) begin
        {e_pc, e_ifid, e_bub, e_hold} = 4'b0010;
        if (ID_branch && IE_memread) m_owed = 1;
      end else begin
        {e_pc, e_ifid, e_bub, e_hold} = 4'b1100;
        e_flush = branch_taken;
      end
      chk("pc_write", {31'd0, pc_b}, {31'd0, e_pc});
      chk("IFID_write", {31'd0, ifid_b}, {31'd0, e_ifid});
      chk("IFID_flush", {31'd0, flush_b}, {31'd0, e_flush});
      chk("IDEX_bubble", {31'd0, bub_b}, {31'd0, e_bub});
      chk("pipe_hold", {31'd0, hold_b}, {31'd0, e_hold});
      chk("small_ctrl", {27'd0, pc_s, ifid_s, flush_s, bub_s, hold_s},
          {27'd0, e_pc, e_ifid, e_flush, e_bub, e_hold});
      chk("stall_count", {16'd0, sc_b}, m_sc_b);
      chk("stall_count_small", {28'd0, sc_s}, m_sc_s);
      chk("mem_timeout", {31'd0, to_b}, {31'd0, m_to_b});
      chk("mem_timeout_small", {31'd0, to_s}, {31'd0, m_to_s});
      // advance model to what the next clock edge produces
      if (!e_pc) begin
        if (m_sc_b < 65535) m_sc_b++;
        if (m_sc_s < 15) m_sc_s++;
      end
      if (m_waiting) begin
        if (mem_ready) begin
          m_waiting = 0;
          m_wait_cycles = 0;
        end else begin
          m_wait_cycles++;
          if (m_wait_cycles >= 4) m_to_s = 1;
          if (m_wait_cycles >= 255) m_to_b = 1;
        end
      end else if (mem_req && !mem_ready) begin
        m_waiting = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; ID_branch = 0;
    IE_memread = 0; IE_writeback = 0; IE_registertowrite = 0;
    mem_req = 0; mem_ready = 0; branch_taken = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(negedge clk);
    chk("lit_rst_bubble", {31'd0, bub_b}, 1);
    next(); next();
    rst_n = 1;
    @(negedge clk);
    chk("lit_idle_pc", {31'd0, pc_b}, 1);
    next();

    // load-use: one bubble
    IE_memread = 1; IE_writeback = 1; IE_registertowrite = 8; ID_rs = 8;
    @(negedge clk);
    chk("lit_lu_pc", {31'd0, pc_b}, 0);
    chk("lit_lu_bub", {31'd0, bub_b}, 1);
    next(); idle();
    @(negedge clk);
    chk("lit_lu_after_pc", {31'd0, pc_b}, 1);
    chk("lit_lu_count", {16'd0, sc_b}, 1);
    next();

    // register 0 never hazards
    IE_memread = 1; IE_writeback = 1; IE_registertowrite = 0; ID_rs = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lit_r0_pc", {31'd0, pc_b}, 1);
      next();
    end
    idle();

    // load-to-branch: two bubbles
    IE_memread = 1; IE_writeback = 1; IE_registertowrite = 9; ID_branch = 1; ID_rt = 9;
    @(negedge clk);
    chk("lit_lb_pc1", {31'd0, pc_b}, 0);
    next(); idle();
    @(negedge clk);
    chk("lit_lb_pc2", {31'd0, pc_b}, 0);
    chk("lit_lb_bub2", {31'd0, bub_b}, 1);
    next();
    @(negedge clk);
    chk("lit_lb_pc3", {31'd0, pc_b}, 1);
    chk("lit_lb_count", {16'd0, sc_b}, 3);
    next();

    // long wait: small instance times out after its 4th wait cycle
    for (int k = 1; k <= 10; k++) begin
      mem_req = 1; mem_ready = 0;
      @(negedge clk);
      chk("lit_to_hold", {31'd0, hold_b}, 1);
      if (k == 5) chk("lit_to_before", {31'd0, to_s}, 0);
      if (k == 6) chk("lit_to_after", {31'd0, to_s}, 1);
      next();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("lit_to_ready_hold", {31'd0, hold_b}, 1);
    next(); idle();
    @(negedge clk);
    chk("lit_to_sticky", {31'd0, to_s}, 1);
    chk("lit_to_big", {31'd0, to_b}, 0);
    chk("lit_to_count", {16'd0, sc_b}, 14);
    next();

    // 5-cycle memory wait: 6 frozen cycles
    for (int k = 0; k < 6; k++) begin
      mem_req = 1; mem_ready = (k == 5);
      @(negedge clk);
      chk("lit_mw_hold", {31'd0, hold_b}, 1);
      next();
    end
    idle();
    @(negedge clk);
    chk("lit_mw_hold_off", {31'd0, hold_b}, 0);
    chk("lit_mw_count", {16'd0, sc_b}, 20);
    chk("lit_mw_sat_small", {28'd0, sc_s}, 15);
    chk("lit_mw_timeout", {31'd0, to_b}, 0);
    next();

    // flush, then branch_taken ignored while stalled
    branch_taken = 1;
    @(negedge clk);
    chk("lit_flush", {31'd0, flush_b}, 1);
    next();
    IE_memread = 1; IE_writeback = 1; IE_registertowrite = 8; ID_rs = 8;
    @(negedge clk);
    chk("lit_flush_stalled", {31'd0, flush_b}, 0);
    next(); idle();
    @(negedge clk);
    chk("lit_flush_off", {31'd0, flush_b}, 0);
    chk("lit_flush_count", {16'd0, sc_b}, 21);
    next();

    // reset while the second bubble is pending
    IE_memread = 1; IE_writeback = 1; IE_registertowrite = 9; ID_branch = 1; ID_rt = 9;
    next(); idle();
    rst_n = 0;
    @(negedge clk);
    chk("lit_rst_count", {16'd0, sc_b}, 0);
    chk("lit_rst_to_small", {31'd0, to_s}, 0);
    next();
    rst_n = 1;
    @(negedge clk);
    chk("lit_rst_no_owed", {31'd0, pc_b}, 1);
    next();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      ID_rs = 5'($urandom_range(0, 3));
      ID_rt = 5'($urandom_range(0, 3));
      IE_registertowrite = 5'($urandom_range(0, 3));
      ID_uses_rt = 1'($urandom_range(0, 1));
      ID_branch = ($urandom_range(0, 3) == 0);
      IE_memread = ($urandom_range(0, 2) == 0);
      IE_writeback = ($urandom_range(0, 1) == 1);
      mem_req = ($urandom_range(0, 4) == 0);
      mem_ready = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      next();
    end
    rst_n = 1;
    idle();
    next();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
